// File: rtl/vr_fifo_pkg.sv
// Shared types and helpers for the parameterised valid-ready FIFO.
// Optional peak-occupancy output is enabled with VR_FIFO_PARAM_WATERMARK_EN.
package vr_fifo_pkg;

    localparam int unsigned HS_W = 2;

    // Handshake status for one cycle
    typedef struct packed {
        logic in_shake;
        logic out_shake;
    } hs_t;

    // Wrapping increment for pointers over a non-power-of-two range
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vr_fifo_mem.sv
// Storage array: single write port, asynchronous read port.
// Kept separate so an SRAM macro can replace it later.
module vr_fifo_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vr_fifo_param.sv
// Valid-ready synchronous FIFO for any DEPTH >= 2 with flush, level and almost flags.
// Define VR_FIFO_PARAM_WATERMARK_EN to add the peak_level output.
module vr_fifo_param
    import vr_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned AF_LEVEL = DEPTH - 1,
    parameter  int unsigned AE_LEVEL = 1,
    localparam int unsigned PTR_W    = $clog2(DEPTH),
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef VR_FIFO_PARAM_WATERMARK_EN
    output logic [CNT_W-1:0]  peak_level,
`endif
    output logic [CNT_W-1:0]  level,
    output logic              almost_full,
    output logic              almost_empty
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rdy_q;
    logic             vld_q;
    logic             mem_we;
    hs_t              hs;
    logic [CNT_W-1:0] level_next;

    // Handshake outputs are masked by en but otherwise come straight from flops
    assign in_ready  = en & rdy_q;
    assign out_valid = en & vld_q;

    always_comb begin
        hs           = '0;
        hs.in_shake  = in_valid & in_ready;
        hs.out_shake = out_valid & out_ready;
        // in_shake only when level < DEPTH and out_shake only when level > 0
        level_next   = level + CNT_W'(hs.in_shake) - CNT_W'(hs.out_shake);
        mem_we       = en & ~flush & hs.in_shake;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rdy_q        <= 1'b0;
            vld_q        <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (en) begin
            if (flush) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level        <= '0;
                rdy_q        <= 1'b1;
                vld_q        <= 1'b0;
                almost_full  <= 1'b0;
                almost_empty <= 1'b1;
            end else begin
                if (hs.in_shake) begin
                    wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
                end
                if (hs.out_shake) begin
                    rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
                end
                level        <= level_next;
                rdy_q        <= (level_next < CNT_W'(DEPTH));
                vld_q        <= (level_next != '0);
                almost_full  <= (level_next >= CNT_W'(AF_LEVEL));
                almost_empty <= (level_next <= CNT_W'(AE_LEVEL));
            end
        end
    end

`ifdef VR_FIFO_PARAM_WATERMARK_EN
    // Highest occupancy seen since reset or the last flush
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            peak_level <= '0;
        end else if (en) begin
            if (flush) begin
                peak_level <= '0;
            end else if (level_next > peak_level) begin
                peak_level <= level_next;
            end
        end
    end
`endif

    vr_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_vr_fifo_param.sv
// Scoreboard bench for vr_fifo_param at DEPTH=5 (non-power-of-two), AF_LEVEL=4.
// Exercises peak_level too when VR_FIFO_PARAM_WATERMARK_EN is defined.
module tb_vr_fifo_param;

    localparam int unsigned DEPTH  = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned AF     = DEPTH - 1;
    localparam int unsigned AE     = 1;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  level;
    logic              almost_full;
    logic              almost_empty;
`ifdef VR_FIFO_PARAM_WATERMARK_EN
    logic [CNT_W-1:0]  peak_level;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [DATA_W-1:0] sb[$];
    int unsigned mlev  = 0;
    int unsigned mpeak = 0;

    always #5 clk = ~clk;

    vr_fifo_param #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
`ifdef VR_FIFO_PARAM_WATERMARK_EN
        .peak_level   (peak_level),
`endif
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Status outputs against the bench's occupancy model
    task automatic chk_status();
        chk("level", 32'(level), 32'(mlev));
        chk("in_ready", 32'(in_ready), 32'(en && mlev < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(en && mlev != 0));
        chk("almost_full", 32'(almost_full), 32'(mlev >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(mlev <= AE));
`ifdef VR_FIFO_PARAM_WATERMARK_EN
        chk("peak_level", 32'(peak_level), 32'(mpeak));
`endif
    endtask

    // One clock: observe handshakes, update the model, clock, then check
    task automatic step();
        logic is, os;
        logic [DATA_W-1:0] exp_d;
        #1;
        is = in_valid && in_ready;
        os = out_valid && out_ready;
        if (en && flush) begin
            sb.delete();
            mlev  = 0;
            mpeak = 0;
        end else if (en) begin
            if (os) begin
                if (sb.size() == 0) begin
                    chk("data_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_d = sb.pop_front();
                    chk("data", 32'(out_data), 32'(exp_d));
                end
            end
            if (is) sb.push_back(in_data);
            mlev = mlev + (is ? 1 : 0) - (os ? 1 : 0);
            if (mlev > mpeak) mpeak = mlev;
        end
        @(posedge clk);
        #1;
        chk_status();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #3;
        sb.delete();
        mlev  = 0;
        mpeak = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; flush = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        step();
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Fill to full with the reader stalled
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(8'h11 * i);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_level", 32'(level), 32'd5);

        // Read while full: no write this cycle, in_ready back next cycle
        in_data   = 8'h66;
        out_ready = 1'b1;
        step();
        chk("full_rw_level", 32'(level), 32'd4);
        chk("full_rw_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("rw_level_held", 32'(level), 32'd4);
        drain();
        chk("drained_out_valid", 32'(out_valid), 32'd0);

        // Random stalls on both sides across many pointer wraps
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = DATA_W'(8'h80 + i);
            step();
        end
        drain();

        // Flush at level 3 with a write offered in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(8'hA0 + i);
            step();
        end
        flush    = 1'b1;
        in_data  = 8'hEE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Hold with en low at level 2; flush must be ignored meanwhile
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(8'hC0 + i);
            step();
        end
        en        = 1'b0;
        in_data   = 8'hDD;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            step();
        end
        flush = 1'b0;
        chk("en_low_level", 32'(level), 32'd2);
        en = 1'b1;
        drain();

        // Reset in the middle of a stream
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(8'h50 + i);
            step();
        end
        in_valid = 1'b0;
        do_reset();
        step();
        out_ready = 1'b1;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
